// File: rtl/cfu_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfu_if_pkg
// Brief    : Shared types and constants for the CPU<->CFU command initiator.
// Revision : 1.0 - initial release
// ============================================================================
package cfu_if_pkg;

    localparam int FUNC_ID_W = 10;
    localparam int DATA_W    = 32;
    localparam int CLEAR_BIT = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } init_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_pair_t;

    // Replace the accumulator-clear bit of a function id
    function automatic logic [FUNC_ID_W-1:0] make_func_id(
        input logic [FUNC_ID_W-1:0] func,
        input logic                 clr
    );
        logic [FUNC_ID_W-1:0] r;
        r            = func;
        r[CLEAR_BIT] = clr;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfu_operand_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cfu_operand_fifo
// Brief    : Synchronous first-word-fall-through FIFO of operand pairs.
//            Flush empties it in one cycle and also serves as its reset.
// Revision : 1.0 - initial release
// ============================================================================
module cfu_operand_fifo
    import cfu_if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     flush_i,
    input  logic     push_i,
    input  op_pair_t push_data_i,
    input  logic     pop_i,
    output op_pair_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    op_pair_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q;
    logic [PTR_W-1:0]   rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    // Occupancy follows the accepted push/pop pair; simultaneous ones cancel
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers and count; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the count
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/cfu_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : cfu_cmd_initiator
// Brief    : Streams a job of N commands from an operand FIFO into a CFU,
//            one outstanding command at a time, collecting the last result
//            plus sticky error status.
// Revision : 1.0 - initial release
// ============================================================================
module cfu_cmd_initiator
    import cfu_if_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int COUNT_W     = 16,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [COUNT_W-1:0]   job_count,
    input  logic [FUNC_ID_W-1:0] job_func,
    input  logic                 job_clear_first,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [DATA_W-1:0]    op_a,
    input  logic [DATA_W-1:0]    op_b,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [FUNC_ID_W-1:0] cmd_payload_function_id,
    output logic [DATA_W-1:0]    cmd_payload_inputs_0,
    output logic [DATA_W-1:0]    cmd_payload_inputs_1,
    input  logic                 rsp_valid,
    output logic                 rsp_ready,
    input  logic                 rsp_payload_response_ok,
    input  logic [DATA_W-1:0]    rsp_payload_outputs_0,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    result,
    output logic [COUNT_W-1:0]   issued,
    output logic                 err_nok,
    output logic                 err_timeout
);

    localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);

    init_state_e          state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [FUNC_ID_W-1:0] func_q, func_d;
    logic                 clr_first_q, clr_first_d;
    logic [COUNT_W-1:0]   issued_q, issued_d;
    logic [DATA_W-1:0]    result_q, result_d;
    logic                 err_nok_q, err_nok_d;
    logic                 err_tmo_q, err_tmo_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    logic                 fifo_pop;
    logic                 fifo_abort;
    logic                 fifo_full;
    logic                 fifo_empty;
    op_pair_t             fifo_head;
    op_pair_t             fifo_in;

    assign fifo_in = '{a: op_a, b: op_b};

    cfu_operand_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .flush_i     (reset || fifo_abort),
        .push_i      (op_valid),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign op_ready                = !fifo_full;
    assign cmd_payload_inputs_0    = fifo_head.a;
    assign cmd_payload_inputs_1    = fifo_head.b;
    assign cmd_payload_function_id = make_func_id(func_q,
                                         (issued_q == '0) ? clr_first_q : 1'b0);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign issued      = issued_q;
    assign err_nok     = err_nok_q;
    assign err_timeout = err_tmo_q;

    // Next-state, handshake outputs and job bookkeeping
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        func_d      = func_q;
        clr_first_d = clr_first_q;
        issued_d    = issued_q;
        result_d    = result_q;
        err_nok_d   = err_nok_q;
        err_tmo_d   = err_tmo_q;
        tmo_d       = tmo_q;
        cmd_valid   = 1'b0;
        rsp_ready   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_abort  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d     = job_count;
                    func_d      = job_func;
                    clr_first_d = job_clear_first;
                    issued_d    = '0;
                    err_nok_d   = 1'b0;
                    err_tmo_d   = 1'b0;
                    state_d     = (job_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // Valid depends only on FIFO occupancy, never on cmd_ready
                cmd_valid = !fifo_empty;
                if (!fifo_empty && cmd_ready) begin
                    fifo_pop = 1'b1;
                    if (issued_q != count_q) issued_d = issued_q + COUNT_W'(1);
                    tmo_d   = '0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    // A response in the final timeout cycle still wins
                    result_d  = rsp_payload_outputs_0;
                    err_nok_d = err_nok_q | ~rsp_payload_response_ok;
                    state_d   = (issued_q == count_q) ? DONE : ISSUE;
                end else if (tmo_q == TMO_W'(RSP_TIMEOUT - 1)) begin
                    err_tmo_d  = 1'b1;
                    fifo_abort = 1'b1;
                    state_d    = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and job registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            func_q      <= '0;
            clr_first_q <= 1'b0;
            issued_q    <= '0;
            result_q    <= '0;
            err_nok_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            func_q      <= func_d;
            clr_first_q <= clr_first_d;
            issued_q    <= issued_d;
            result_q    <= result_d;
            err_nok_q   <= err_nok_d;
            err_tmo_q   <= err_tmo_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfu_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfu_cmd_initiator
// Brief    : Directed bench for cfu_cmd_initiator with a 4-lane MAC CFU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfu_cmd_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] job_count;
    logic [9:0]  job_func;
    logic        job_clear_first;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a, op_b;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic        rsp_payload_response_ok = 1'b1;
    logic [31:0] rsp_payload_outputs_0 = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [15:0] issued;
    logic        err_nok, err_timeout;

    cfu_cmd_initiator #(
        .FIFO_DEPTH  (4),
        .COUNT_W     (16),
        .RSP_TIMEOUT (8)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .job_count               (job_count),
        .job_func                (job_func),
        .job_clear_first         (job_clear_first),
        .op_valid                (op_valid),
        .op_ready                (op_ready),
        .op_a                    (op_a),
        .op_b                    (op_b),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_response_ok (rsp_payload_response_ok),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .busy                    (busy),
        .done                    (done),
        .result                  (result),
        .issued                  (issued),
        .err_nok                 (err_nok),
        .err_timeout             (err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder configuration (written by the stimulus thread only)
    int hold_cfg   = 0;
    int dly_cfg    = 0;
    bit never      = 1'b0;
    int nok_at     = -1;
    bit resp_abort = 1'b0;
    bit mon_busy   = 1'b0;

    // Responder state and monitors (written by the responder only)
    int          hold_cnt = 0;
    int          dly      = 0;
    bit          pending  = 1'b0;
    int          cmd_total = 0;
    int          bp_seen = 0, bp_bad = 0;
    int          wcnt = 0, dcnt = 0, busy_low = 0;
    int          acc = 0;
    logic [73:0] snap = '0;
    logic [9:0]  fid_log [64];
    logic [31:0] in0_log [64];
    bit          rsp_hs_prev = 1'b0;

    // 4-lane signed MAC with +128 input offset
    function automatic int mac4(input logic [31:0] a, input logic [31:0] b);
        int  s;
        byte sa, sb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            sa = a[8*i +: 8];
            sb = b[8*i +: 8];
            s += (int'(sa) + 128) * int'(sb);
        end
        return s;
    endfunction

    // CFU model: drives cmd_ready/rsp_* on the falling edge
    always @(negedge clk) begin
        if (rsp_ready) wcnt++;
        if (done) dcnt++;
        if (mon_busy && !busy) busy_low++;
        if (reset || resp_abort) begin
            cmd_ready = 1'b0;
            rsp_valid = 1'b0;
            pending   = 1'b0;
            hold_cnt  = 0;
        end else if (pending) begin
            cmd_ready = 1'b0;
            if (rsp_valid) begin
                rsp_valid = 1'b0;
                pending   = 1'b0;
            end else if (!never) begin
                if (dly == 0) rsp_valid = 1'b1;
                else dly--;
            end
        end else if (cmd_valid) begin
            if (hold_cnt < hold_cfg) begin
                if (hold_cnt == 0)
                    snap = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};
                else if (snap !== {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1})
                    bp_bad++;
                bp_seen++;
                hold_cnt++;
                cmd_ready = 1'b0;
            end else begin
                cmd_ready = 1'b1;
                pending   = 1'b1;
                hold_cnt  = 0;
                dly       = dly_cfg;
                fid_log[cmd_total % 64] = cmd_payload_function_id;
                in0_log[cmd_total % 64] = cmd_payload_inputs_0;
                if (cmd_payload_function_id[3]) acc = 0;
                acc += mac4(cmd_payload_inputs_0, cmd_payload_inputs_1);
                rsp_payload_outputs_0   = acc;
                rsp_payload_response_ok = (cmd_total != nok_at);
                cmd_total++;
            end
        end else begin
            if (hold_cnt > 0) bp_bad++;
            cmd_ready = 1'b0;
        end
        rsp_hs_prev = rsp_valid && rsp_ready;
    end

    // Result captured after the first response of the MAC job
    logic [31:0] first_res = '0;
    bit          grab      = 1'b0;
    always @(negedge clk) begin
        if (grab && rsp_hs_prev) first_res = result;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        while (!op_ready && n < 50) begin
            tick();
            n++;
        end
        if (!op_ready) check("push_ready", op_ready, 1);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] cnt, input logic [9:0] func, input logic cf);
        job_count       = cnt;
        job_func        = func;
        job_clear_first = cf;
        start           = 1'b1;
        tick();
        start           = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check("done_seen", done, 1);
    endtask

    int c0, c1, d0, w0, b0, bl0, n;

    initial begin
        reset = 1'b1; start = 1'b0; job_count = '0; job_func = '0;
        job_clear_first = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        check("rst_errs", {err_nok, err_timeout}, 0);
        check("rst_result", result, 0);
        check("rst_issued", issued, 0);
        check("rst_op_ready", op_ready, 1);

        // Basic MAC job
        c0 = cmd_total; d0 = dcnt; grab = 1'b1;
        push(32'hFFFF_FFFF, 32'h0101_0101);
        push(32'hFFFF_FFFF, 32'h0101_0101);
        do_start(2, 10'h000, 1'b1);
        wait_done();
        grab = 1'b0;
        check("mac_fid0", fid_log[c0 % 64], 10'h008);
        check("mac_fid1", fid_log[(c0 + 1) % 64], 10'h000);
        check("mac_res1", first_res, 32'h0000_01FC);
        check("mac_res_done", result, 32'h0000_03F8);
        check("mac_issued", issued, 2);
        tick();
        check("mac_done_low", done, 0);
        check("mac_done_pulses", dcnt - d0, 1);

        // Backpressure: cmd_ready held low for 5 cycles
        c0 = cmd_total; b0 = bp_seen; hold_cfg = 5;
        push(32'h1111_1111, 32'h2222_2222);
        push(32'h3333_3333, 32'h4444_4444);
        do_start(1, 10'h3FF, 1'b0);
        wait_done();
        hold_cfg = 0;
        check("bp_hold_cycles", bp_seen - b0, 5);
        check("bp_stable", bp_bad, 0);
        check("bp_cmds", cmd_total - c0, 1);
        check("bp_fid", fid_log[c0 % 64], 10'h3F7);
        check("bp_in0", in0_log[c0 % 64], 32'h1111_1111);
        check("bp_result", result, 32'h0000_5100);
        tick();
        do_start(1, 10'h000, 1'b1);
        wait_done();
        check("bp_next_in0", in0_log[(c0 + 1) % 64], 32'h3333_3333);
        check("bp_next_result", result, 32'h0000_BE30);
        tick();

        // Starved FIFO
        c0 = cmd_total; bl0 = busy_low;
        push(32'h1, 32'h1);
        do_start(3, 10'h000, 1'b1);
        mon_busy = 1'b1;
        repeat (10) tick();
        check("st_issued1", issued, 1);
        check("st_idle_valid1", cmd_valid, 0);
        push(32'h1, 32'h1);
        repeat (10) tick();
        check("st_issued2", issued, 2);
        check("st_idle_valid2", cmd_valid, 0);
        push(32'h1, 32'h1);
        wait_done();
        mon_busy = 1'b0;
        check("st_issued3", issued, 3);
        check("st_busy_held", busy_low - bl0, 0);
        check("st_fid0", fid_log[c0 % 64], 10'h008);
        check("st_fid1", fid_log[(c0 + 1) % 64], 10'h000);
        check("st_fid2", fid_log[(c0 + 2) % 64], 10'h000);
        check("st_result", result, 32'h0000_0183);
        tick();

        // Timeout: no response ever arrives
        repeat (4) push(32'h1, 32'h1);
        check("to_full", op_ready, 0);
        never = 1'b1; w0 = wcnt;
        do_start(2, 10'h000, 1'b1);
        wait_done();
        check("to_flag", err_timeout, 1);
        check("to_wait_cycles", wcnt - w0, 8);
        check("to_issued", issued, 1);
        check("to_op_ready", op_ready, 1);
        tick();
        resp_abort = 1'b1; tick(); resp_abort = 1'b0; never = 1'b0;
        do_start(1, 10'h000, 1'b1);
        repeat (3) tick();
        check("to_flushed", cmd_valid, 0);
        check("to_busy_empty", busy, 1);
        check("to_flag_cleared", err_timeout, 0);
        push(32'h1, 32'h1);
        wait_done();
        check("to_after_result", result, 32'h0000_0081);
        tick();

        // Response in the final timeout cycle wins
        dly_cfg = 7; w0 = wcnt;
        push(32'h1, 32'h1);
        do_start(1, 10'h000, 1'b1);
        wait_done();
        dly_cfg = 0;
        check("edge_no_timeout", err_timeout, 0);
        check("edge_wait_cycles", wcnt - w0, 8);
        check("edge_result", result, 32'h0000_0081);
        tick();

        // Status: response_ok=0 on command 2 of 3
        nok_at = cmd_total + 1;
        repeat (3) push(32'h1, 32'h1);
        do_start(3, 10'h000, 1'b1);
        wait_done();
        nok_at = -1;
        check("nok_sticky", err_nok, 1);
        check("nok_issued", issued, 3);
        tick();
        d0 = dcnt;
        push(32'h1, 32'h1);
        do_start(1, 10'h000, 1'b1);
        check("nok_cleared", err_nok, 0);
        do_start(5, 10'h000, 1'b0);
        wait_done();
        check("busy_start_issued", issued, 1);
        repeat (3) tick();
        check("busy_start_idle", busy, 0);
        check("busy_start_pulses", dcnt - d0, 1);

        // Zero-length job
        c1 = cmd_total;
        do_start(0, 10'h3FF, 1'b1);
        check("zero_done", done, 1);
        check("zero_issued", issued, 0);
        tick();
        check("zero_done_low", done, 0);
        check("zero_no_cmd", cmd_total - c1, 0);

        // Mid-job reset while waiting for a response
        push(32'h1, 32'h1);
        push(32'h1, 32'h1);
        never = 1'b1;
        do_start(1, 10'h000, 1'b1);
        n = 0;
        while (!rsp_ready && n < 20) begin
            tick();
            n++;
        end
        check("mr_in_wait", rsp_ready, 1);
        reset = 1'b1;
        tick();
        check("mr_busy", busy, 0);
        check("mr_cmd_valid", cmd_valid, 0);
        check("mr_rsp_ready", rsp_ready, 0);
        check("mr_op_ready", op_ready, 1);
        check("mr_result", result, 0);
        check("mr_issued", issued, 0);
        check("mr_flags", {done, err_nok, err_timeout}, 0);
        reset = 1'b0; never = 1'b0;
        do_start(1, 10'h000, 1'b1);
        repeat (3) tick();
        check("mr_fifo_empty", cmd_valid, 0);
        push(32'h1, 32'h1);
        wait_done();
        check("mr_after_result", result, 32'h0000_0081);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cfu_cmd_initiator.md
Name: cfu_cmd_initiator

Overview:
- Initiator side of the CPU<->CFU command/response interface: drives cmd_valid/cmd_payload_* into a CFU and accepts rsp_valid/rsp_payload_* back.
- Runs a job of N commands. Operand pairs come from a small operand FIFO fed by an upstream producer (DMA, testbench, or host-side glue).
- Reports the last response word, done/busy status and error flags.
- Lets CFU accelerators be exercised and streamed without the CPU in the loop.

Parameters:
- FIFO_DEPTH, 4, operand-pair FIFO entries (power of two, >=2).
- COUNT_W, 16, width of the job command counter.
- RSP_TIMEOUT, 255, max cycles waiting in WAIT_RSP before abort (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; ignored while busy.
- job_count  in  COUNT_W  number of commands in the job; sampled on start.
- job_func  in  10  {funct7,funct3} used for all commands; sampled on start.
- job_clear_first  in  1  force function_id[3]=1 on the first command; sampled on start.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  FIFO not full.
- op_a  in  32  operand for cmd_payload_inputs_0.
- op_b  in  32  operand for cmd_payload_inputs_1.
- cmd_valid  out  1  command valid to CFU.
- cmd_ready  in  1  CFU accepts command.
- cmd_payload_function_id  out  10  function id.
- cmd_payload_inputs_0  out  32  rs1 value.
- cmd_payload_inputs_1  out  32  rs2 value.
- rsp_valid  in  1  CFU response valid.
- rsp_ready  out  1  initiator accepts response.
- rsp_payload_response_ok  in  1  CFU status.
- rsp_payload_outputs_0  in  32  CFU result.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- result  out  32  last captured rsp_payload_outputs_0.
- issued  out  COUNT_W  commands handshaken in current/last job.
- err_nok  out  1  sticky per job: some response had response_ok=0.
- err_timeout  out  1  sticky per job: response timeout abort.

Behaviour:
- Reset values:
  - busy, done, cmd_valid, rsp_ready, err_nok, err_timeout = 0.
  - result, issued = 0.
  - FIFO empty, so op_ready=1 from the first cycle after reset.
  - FSM in IDLE.
- Reset mid-job: same state next cycle. Any in-flight command or response is dropped, and the FIFO is flushed.
- FSM states are IDLE, ISSUE, WAIT_RSP, DONE. Only one command is outstanding at a time.
- IDLE:
  - On start, latch job_count, job_func and job_clear_first.
  - Clear issued, err_nok and err_timeout. result keeps its last value.
  - job_count==0 goes to DONE; otherwise go to ISSUE.
- ISSUE:
  - cmd_valid = (state==ISSUE) && FIFO non-empty. It must not depend on cmd_ready.
  - Payload comes from the FIFO head (first-word-fall-through). It stays stable while cmd_valid && !cmd_ready.
  - function_id = job_func with bit 3 replaced by (first command ? job_clear_first : 0).
  - On cmd_valid && cmd_ready: pop the FIFO, issued++, clear the timeout counter, go to WAIT_RSP.
  - FIFO empty: wait in ISSUE indefinitely. No timeout applies here.
- WAIT_RSP:
  - rsp_ready=1 combinationally; cmd_valid=0.
  - On rsp_valid: result <= rsp_payload_outputs_0, and err_nok |= ~rsp_payload_response_ok.
  - Then if issued==latched count, go to DONE; else go to ISSUE.
  - Timeout counter increments each cycle with no response. If it reaches RSP_TIMEOUT: set err_timeout, flush the FIFO, go to DONE.
  - A response arriving in the same cycle the counter reaches RSP_TIMEOUT wins: it is captured and no timeout is flagged.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy=1 in ISSUE, WAIT_RSP and DONE.
- Response-before-command (rsp_valid while not in WAIT_RSP): ignored; rsp_ready=0.
- Operand FIFO:
  - Accepts pushes in any state when op_ready.
  - op_ready = !full, registered-count based. A pop in the same cycle does not raise op_ready until the next cycle.
  - Push and pop in the same cycle when non-empty: count unchanged.
  - Pointers wrap at FIFO_DEPTH.
  - Leftover operands after a normal DONE stay queued for the next job.
- Counters: issued saturates at the latched count. No arithmetic is performed on payloads.

Decomposition:
- Package cfu_if_pkg holds:
  - FUNC_ID_W=10, DATA_W=32, CLEAR_BIT=3.
  - typedef enum logic [1:0] init_state_e {IDLE, ISSUE, WAIT_RSP, DONE}.
  - typedef struct packed op_pair_t {a, b}.
- One sub-module: cfu_operand_fifo.
  - Parameterised synchronous FWFT FIFO of op_pair_t with push, pop, flush, full, empty.
  - Its flush is driven by reset or a timeout abort.

Test Plan:
- Basic MAC job:
  - Stimulus: drive the team's 4-lane MAC CFU model; push two pairs (a=0xFFFFFFFF, b=0x01010101); start with count=2, func=0, clear_first=1.
  - First command function_id=0x008; result=0x000001FC after command 1 and 0x000003F8 at done; issued=2; single done pulse.
- Backpressure:
  - Stimulus: CFU holds cmd_ready=0 for 5 cycles.
  - cmd_valid stays 1 with payload and function_id stable all 5 cycles; exactly one pop; no duplicate command.
- Starved FIFO:
  - Stimulus: start count=3 with 1 pair queued; push the next pairs 10 cycles apart.
  - cmd_valid=0 while empty; busy=1 throughout; 3 commands issued; later commands use function_id bit3=0.
- Timeout:
  - Stimulus: responder never asserts rsp_valid; RSP_TIMEOUT=8.
  - err_timeout=1 after 8 WAIT_RSP cycles; FIFO flushed (op_ready=1, empty); done pulses; response arriving exactly at cycle 8 instead captures with err_timeout=0.
- Status and edge cases:
  - Stimulus: response_ok=0 on command 2 of 3.
  - err_nok=1 sticky to done and cleared by the next start; count=0 gives done one cycle after start with no cmd_valid; start while busy is ignored.
- Mid-job reset:
  - Stimulus: assert reset in WAIT_RSP.
  - Next cycle: IDLE, cmd_valid=0, rsp_ready=0, FIFO empty, result=0, all flags 0.
